// File: rtl/mux_rr_pkg.sv
// Shared constants and helpers for the N-channel registered mux.
package mux_rr_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;
  localparam int   MAX_N      = 16;

  // OR-reduction encoder; result is only meaningful for one-hot or zero input.
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++)
      if (oh[i]) idx = idx | 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/mux_rr_n_if.sv
// Producer/consumer bus for mux_rr_n: N request channels in, one registered channel out.
interface mux_rr_n_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/mux_rr_n_rr_arbiter.sv
// Round-robin arbiter: combinational grant, priority starts just after the last winner.
module rr_arbiter
  import mux_rr_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] last;

  always_comb begin : p_grant
    logic [SW-1:0] idx;
    idx   = '0;
    grant = '0;
    for (int k = 1; k <= N; k++) begin
      idx = SW'((int'(last) + k) % N);
      if (grant == '0 && req[idx]) grant[idx] = 1'b1;
    end
  end

  // Reset to N-1 so channel 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n)       last <= SW'(N - 1);
    else if (advance) last <= SW'(onehot_to_idx(16'(grant)));
  end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel W-bit registered mux with per-channel handshakes; fixed-select or round-robin.
module mux_rr_n
  import mux_rr_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  mux_rr_n_if.slave bus
);

  localparam int SW = $clog2(N);

  logic [N-1:0] sel_oh, req, rr_grant, grant;
  logic         slot_free, xfer;
  logic [W-1:0] mux_data;

  // Out-of-range sel matches no lane, so fixed mode then grants nothing.
  always_comb begin
    sel_oh = '0;
    for (int i = 0; i < N; i++)
      sel_oh[i] = (bus.sel == SW'(i));
  end

  assign req = (bus.mode == MODE_FIXED) ? (bus.in_valid & sel_oh) : bus.in_valid;

  rr_arbiter #(.N(N)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (xfer && bus.mode == MODE_RR),
    .grant   (rr_grant)
  );

  assign grant        = (bus.mode == MODE_FIXED) ? req : rr_grant;
  assign slot_free    = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = grant & {N{slot_free & rst_n}};
  assign xfer         = |(bus.in_valid & bus.in_ready);

  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++)
      mux_data = mux_data | (bus.in_data[i*W +: W] & {W{grant[i]}});
  end

  // Load wins over drain, so a simultaneous consume+load leaves no bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= mux_data;
      bus.out_ch    <= SW'(onehot_to_idx(16'(grant)));
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr_n.sv
// Scoreboard bench for mux_rr_n: reference grant model pushes words, output side pops and compares.
module tb_mux_rr_n;
  localparam int N = 4, W = 8, SW = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_rr_n_if #(.N(N), .W(W)) bus ();
  mux_rr_n_if #(.N(6), .W(W)) bus6 ();

  mux_rr_n #(.N(N), .W(W)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  mux_rr_n #(.N(6), .W(W)) dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6));

  typedef struct packed { logic [SW-1:0] ch; logic [W-1:0] data; } word_t;
  word_t q[$];

  int checks = 0, failures = 0;
  logic          m_ovalid;
  logic [SW-1:0] m_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: check at negedge against the model, then advance model and clock.
  task automatic step();
    logic [N-1:0]  g, er;
    logic [SW-1:0] gi;
    logic          sf;
    int            idx;
    word_t         w;
    @(negedge clk);
    g  = '0;
    gi = '0;
    if (bus.mode) begin
      if (int'(bus.sel) < N && bus.in_valid[bus.sel]) begin g[bus.sel] = 1'b1; gi = bus.sel; end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(m_last) + k) % N;
        if (g == '0 && bus.in_valid[idx]) begin g[idx] = 1'b1; gi = SW'(idx); end
      end
    end
    sf = !m_ovalid || bus.out_ready;
    er = (rst_n && sf) ? g : '0;
    chk("in_ready", 32'(bus.in_ready), 32'(er));
    chk("out_valid", 32'(bus.out_valid), 32'(m_ovalid));
    if (m_ovalid) begin
      if (q.size() > 0) begin
        chk("out_data", 32'(bus.out_data), 32'(q[0].data));
        chk("out_ch", 32'(bus.out_ch), 32'(q[0].ch));
        if (bus.out_ready) void'(q.pop_front());
      end else chk("sb_underflow", 32'(q.size()), 32'd1);
    end
    if (!rst_n) begin
      q.delete();
      m_ovalid = 1'b0;
      m_last   = SW'(N - 1);
    end else begin
      if (er != '0) begin
        w.ch   = gi;
        w.data = bus.in_data[gi*W +: W];
        q.push_back(w);
        m_ovalid = 1'b1;
        if (!bus.mode) m_last = gi;
      end else if (bus.out_ready) m_ovalid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.mode      = 1'b0;
    bus.sel       = '0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.out_ready = 1'b1;
    bus6.mode      = 1'b0;
    bus6.sel       = '0;
    bus6.in_valid  = '0;
    bus6.in_data   = '0;
    bus6.out_ready = 1'b1;
    m_ovalid = 1'b0;
    m_last   = SW'(N - 1);

    // Reset held two cycles with all channels requesting
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_data", 32'(bus.out_data), 32'h0);
      chk("rst_out_ch", 32'(bus.out_ch), 32'h0);
      step();
    end
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    rst_n = 1'b1;

    // Round-robin fairness: A0 A1 A2 A3 A0
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_seq_data", 32'(bus.out_data), 32'(8'hA0 + (i % 4)));
      chk("rr_seq_ch", 32'(bus.out_ch), 32'(i % 4));
    end

    // Skip and wrap
    bus.in_valid = 4'b0010; step();
    chk("skip_ch1", 32'(bus.out_ch), 32'd1);
    bus.in_valid = 4'b0001; step();
    chk("wrap_ch0", 32'(bus.out_ch), 32'd0);
    bus.in_valid = 4'b1001; step();
    chk("next_ch3", 32'(bus.out_ch), 32'd3);

    // Backpressure
    bus.in_valid = 4'b1111; step();
    chk("bp_load", 32'(bus.out_data), 32'hA0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", 32'(bus.out_data), 32'hA0);
    end
    bus.out_ready = 1'b1; step();
    chk("bp_swap_data", 32'(bus.out_data), 32'hA1);
    chk("bp_swap_valid", 32'(bus.out_valid), 32'h1);

    // Fixed mode
    bus.mode = 1'b1; bus.sel = 2'd2;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fix_ch", 32'(bus.out_ch), 32'd2);
      chk("fix_data", 32'(bus.out_data), 32'hA2);
    end

    // Reset mid-stream under backpressure
    bus.mode = 1'b0; bus.out_ready = 1'b0; step();
    rst_n = 1'b0; step();
    chk("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    rst_n = 1'b1; bus.out_ready = 1'b1; step();
    chk("mid_rst_restart_ch", 32'(bus.out_ch), 32'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      bus.in_data   = $urandom;
      bus.in_valid  = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.mode      = ($urandom_range(0, 3) == 0);
      bus.sel       = 2'($urandom_range(0, 3));
      rst_n         = ($urandom_range(0, 49) != 0);
      step();
    end
    rst_n = 1'b1;
    bus.in_valid = '0;

    // N=6 fixed mode: sel=5 loads, sel=7 grants nothing and drains
    bus6.mode     = 1'b1;
    bus6.sel      = 3'd5;
    bus6.in_valid = 6'h3f;
    for (int i = 0; i < 6; i++) bus6.in_data[i*W +: W] = 8'(8'hB0 + i);
    @(negedge clk);
    chk("n6_ready_sel5", 32'(bus6.in_ready), 32'h20);
    @(posedge clk); #1;
    chk("n6_valid", 32'(bus6.out_valid), 32'h1);
    chk("n6_data", 32'(bus6.out_data), 32'hB5);
    chk("n6_ch", 32'(bus6.out_ch), 32'd5);
    bus6.sel = 3'd7;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("n6_ready_sel7", 32'(bus6.in_ready), 32'h0);
      @(posedge clk); #1;
      chk("n6_drained", 32'(bus6.out_valid), 32'h0);
      chk("n6_data_kept", 32'(bus6.out_data), 32'hB5);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_n.md
Name: mux_rr_n

Overview:
- Parametrised N-channel, W-bit registered multiplexer. Successor to the 8-bit 2:1 combinational mux.
- Adds per-channel valid/ready handshakes and a registered output stage.
- Two selection modes: fixed (external select, as in the old mux) and round-robin arbitration.
- Sits between several producer blocks and one shared consumer bus.

Parameters:
- N, 4, number of input channels (2..16).
- W, 8, data width per channel in bits.
- SW, $clog2(N), width of the select and channel-ID fields (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset. One clock; reset is synchronous and active-low.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SW  channel index used when mode = 1.
- out_data  output  W  registered selected data.
- out_ch  output  SW  registered index of the channel that sourced out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - out_valid = 0, out_data = 0, out_ch = 0.
  - RR pointer last = N-1, so channel 0 has highest priority after reset.
  - in_ready = 0 while rst_n = 0. No transfer is accepted in a reset cycle.
- Output slot is free when (!out_valid || out_ready). Full throughput: one word per cycle when out_ready stays high.
- Request vector:
  - mode = 0: req = in_valid.
  - mode = 1: req = in_valid & onehot(sel). If sel >= N, req = 0 and no channel is granted.
- Grant:
  - mode = 0: first set bit of req, searching from (last+1) mod N upward with wrap-around.
  - mode = 1: grant = req.
  - At most one grant bit is set.
- Handshake:
  - in_ready[i] = grant[i] & slot_free & rst_n.
  - A transfer on channel i occurs when in_valid[i] & in_ready[i].
  - Ungranted channels see in_ready = 0 and must hold their data.
- Load: on a transfer, the next edge sets out_data = in_data[i], out_ch = i, out_valid = 1. Input-to-output latency is exactly 1 cycle.
- Hold: when out_valid & !out_ready, out_data, out_ch and out_valid stay stable and all in_ready = 0 (backpressure).
- Drain: when out_valid & out_ready and no transfer occurs, out_valid -> 0 at the next edge. out_data and out_ch keep their last values.
- Simultaneous drain and load: out_valid stays 1 and the new word replaces the old one in the same edge. No bubble.
- Pointer: last updates to the granted index only on a transfer and only in mode 0. In mode 1 the pointer is frozen.
- Mode or sel change mid-stream: takes effect in the same cycle's combinational grant. The word already in the output register is not affected.
- N = 2 with mode = 1 must match the old mux's select behaviour, with one added cycle of latency.
- Reset asserted mid-operation: the next edge clears out_valid; the pending word is dropped.

Decomposition:
- Package mux_rr_pkg holds:
  - constants MODE_RR = 1'b0 and MODE_FIXED = 1'b1;
  - function onehot_to_idx.
- One sub-module rr_arbiter (parameter N):
  - inputs: clk, rst_n, req[N-1:0], advance;
  - output: grant[N-1:0], combinational;
  - owns the last pointer.
- The top level does request masking, the data mux (AND-OR over grant) and the output register.

Test Plan (N = 4, W = 8):
1. Reset: hold rst_n = 0 for 2 cycles with in_valid = 4'b1111 -> in_ready = 0, out_valid = 0, out_data = 8'h00 throughout; first grant after release goes to channel 0.
2. Round-robin fairness:
   - Stimulus: mode = 0; in_valid = 4'b1111 held; data ch0..3 = 8'hA0, A1, A2, A3; out_ready = 1.
   - Response: out_data sequence A0, A1, A2, A3, A0 on consecutive cycles; out_ch = 0, 1, 2, 3, 0.
3. Skip and wrap: mode = 0, after last = 1, in_valid = 4'b0001 -> channel 0 granted via wrap; then in_valid = 4'b1001 -> channel 3 granted next.
4. Backpressure:
   - Stimulus: out_ready = 0 after the first load of 8'hA0.
   - Response: out_data stays A0 and all in_ready = 0 for 5 cycles.
   - Then raise out_ready for 1 cycle -> A0 is consumed, A1 loads on the same edge, and out_valid never drops.
5. Fixed mode:
   - mode = 1, sel = 2, in_valid = 4'b1111 -> only ch2 sees in_ready; out_data = A2 repeatedly with out_ch = 2.
   - sel = 5 is not representable at SW = 2; use N = 6 with sel = 7 -> no grant, and out_valid drops after drain.
6. Reset mid-stream: assert rst_n = 0 while out_valid = 1 and out_ready = 0 -> out_valid = 0 next edge, word dropped; the RR restart grants channel 0 first.
